operand_fetch: RTL and testbench

Operand-fetch stage that sits on the read side of the 16 x 16 register file. Each cycle it drives the file's two combinational read addresses from the incoming instruction and captures both source operands into a registered output slot. A per-register pending-write scoreboard stalls any instruction whose sources or destination are still awaiting writeback, so the execute stage never sees stale data. Valid/ready handshakes on both sides decouple it from decode and execute.

---
 rtl/operand_fetch.sv | 99 +++++++++
 tb/tb_operand_fetch.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - operand fetch stage with pending-write scoreboard
// Reads two sources from the register file and stalls on pending writebacks.
module operand_fetch #(
  parameter int N = 16,
  parameter int M = 4,
  parameter int O = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] in_rd,
  input  logic [M-1:0] in_rs,
  input  logic [M-1:0] in_rt,
  input  logic         in_rd_we,
  input  logic         in_rs_used,
  input  logic         in_rt_used,
  output logic [M-1:0] rf_readAddr0,
  output logic [M-1:0] rf_readAddr1,
  input  logic [N-1:0] rf_dOut0,
  input  logic [N-1:0] rf_dOut1,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_a,
  output logic [N-1:0] out_b,
  output logic [M-1:0] out_rd,
  output logic         out_rd_we,
  input  logic         wb_valid,
  input  logic [M-1:0] wb_addr,
  output logic [15:0]  stall_count
);

  typedef enum logic {RUN, STALL} cycle_state_t;

  logic [O-1:0] pending;
  logic [O-1:0] pending_nxt;
  logic         hazard;
  logic         slot_free;
  logic         accept;
  cycle_state_t cycle_state;

  assign rf_readAddr0 = in_rs;
  assign rf_readAddr1 = in_rt;

  always_comb begin
    hazard    = (in_rs_used & pending[in_rs]) |
                (in_rt_used & pending[in_rt]) |
                (in_rd_we   & pending[in_rd]);
    slot_free = !out_valid | out_ready;
    in_ready  = slot_free & !hazard;
    accept    = in_valid & in_ready;
  end

  // Only hazard stalls are counted; plain backpressure stays in RUN.
  always_comb begin
    cycle_state = RUN;
    if (in_valid && hazard && slot_free) begin
      cycle_state = STALL;
    end
  end

  // Set is applied after clear so a new writer keeps ownership.
  always_comb begin
    pending_nxt = pending;
    if (wb_valid) begin
      pending_nxt[wb_addr] = 1'b0;
    end
    if (accept && in_rd_we) begin
      pending_nxt[in_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending     <= '0;
      out_valid   <= 1'b0;
      out_a       <= '0;
      out_b       <= '0;
      out_rd      <= '0;
      out_rd_we   <= 1'b0;
      stall_count <= '0;
    end else begin
      pending <= pending_nxt;
      if (accept) begin
        out_valid <= 1'b1;
        out_a     <= rf_dOut0;
        out_b     <= rf_dOut1;
        out_rd    <= in_rd;
        out_rd_we <= in_rd_we;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (cycle_state == STALL && stall_count != 16'hFFFF) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed self-checking bench for operand_fetch
// A behavioural register file feeds the read ports and absorbs writebacks.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_rd;
  logic [3:0]  in_rs;
  logic [3:0]  in_rt;
  logic        in_rd_we;
  logic        in_rs_used;
  logic        in_rt_used;
  logic [3:0]  rf_readAddr0;
  logic [3:0]  rf_readAddr1;
  logic [15:0] rf_dOut0;
  logic [15:0] rf_dOut1;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_a;
  logic [15:0] out_b;
  logic [3:0]  out_rd;
  logic        out_rd_we;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic [15:0] stall_count;

  logic [15:0] regs [16];
  int checks = 0;
  int failures = 0;

  operand_fetch #(.N(16), .M(4), .O(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd_we(in_rd_we), .in_rs_used(in_rs_used), .in_rt_used(in_rt_used),
    .rf_readAddr0(rf_readAddr0), .rf_readAddr1(rf_readAddr1),
    .rf_dOut0(rf_dOut0), .rf_dOut1(rf_dOut1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  assign rf_dOut0 = regs[rf_readAddr0];
  assign rf_dOut1 = regs[rf_readAddr1];

  always @(posedge clk) begin
    if (!rst && wb_valid) regs[wb_addr] <= wb_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] rd, input logic [3:0] rs,
                       input logic [3:0] rt, input logic we, input logic su, input logic tu);
    in_valid = v; in_rd = rd; in_rs = rs; in_rt = rt;
    in_rd_we = we; in_rs_used = su; in_rt_used = tu;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] vec_rs [4];
  logic [3:0] vec_rt [4];

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 16'h1000 + 16'(i);
    regs[3] = 16'h1234;
    regs[5] = 16'hABCD;
    vec_rs[0] = 4'd1;  vec_rt[0] = 4'd2;
    vec_rs[1] = 4'd4;  vec_rt[1] = 4'd6;
    vec_rs[2] = 4'd8;  vec_rt[2] = 4'd9;
    vec_rs[3] = 4'd10; vec_rt[3] = 4'd11;

    // Reset with junk on both handshakes
    rst = 1'b1; out_ready = 1'b1;
    wb_valid = 1'b1; wb_addr = 4'd4; wb_data = 16'hDEAD;
    drive(1'b1, 4'd9, 4'd3, 4'd5, 1'b1, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; wb_valid = 1'b0;
    drive(1'b0, 4'd9, 4'd3, 4'd5, 1'b1, 1'b1, 1'b1);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_a", 32'(out_a), 32'h0);
    check("rst_out_b", 32'(out_b), 32'h0);
    check("rst_out_rd", 32'(out_rd), 32'h0);
    check("rst_out_rd_we", 32'(out_rd_we), 32'h0);
    check("rst_stall_count", 32'(stall_count), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);

    // Streaming
    @(negedge clk);
    drive(1'b1, 4'd0, 4'd3, 4'd5, 1'b0, 1'b1, 1'b1);
    #1;
    check("stream_raddr0", 32'(rf_readAddr0), 32'h3);
    check("stream_raddr1", 32'(rf_readAddr1), 32'h5);
    step();
    check("stream_valid", 32'(out_valid), 32'h1);
    check("stream_a", 32'(out_a), 32'h1234);
    check("stream_b", 32'(out_b), 32'hABCD);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 4'd0, vec_rs[i], vec_rt[i], 1'b0, 1'b1, 1'b1);
      #1;
      check($sformatf("b2b_ready%0d", i), 32'(in_ready), 32'h1);
      step();
      check($sformatf("b2b_valid%0d", i), 32'(out_valid), 32'h1);
      check($sformatf("b2b_a%0d", i), 32'(out_a), 32'h1000 + 32'(vec_rs[i]));
      check($sformatf("b2b_b%0d", i), 32'(out_b), 32'h1000 + 32'(vec_rt[i]));
    end
    @(negedge clk);
    drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("drain_valid", 32'(out_valid), 32'h0);

    // RAW hazard on R7
    @(negedge clk);
    drive(1'b1, 4'd7, 4'd1, 4'd2, 1'b1, 1'b1, 1'b1);
    step();
    check("raw_writer_rd", 32'(out_rd), 32'h7);
    check("raw_writer_we", 32'(out_rd_we), 32'h1);
    @(negedge clk);
    drive(1'b1, 4'd0, 4'd7, 4'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      #1;
      check($sformatf("raw_ready%0d", i), 32'(in_ready), 32'h0);
      step();
      check($sformatf("raw_stall%0d", i), 32'(stall_count), 32'(i));
      @(negedge clk);
    end
    wb_valid = 1'b1; wb_addr = 4'd7; wb_data = 16'h7777;
    #1;
    check("raw_no_bypass", 32'(in_ready), 32'h0);
    step();
    check("raw_stall4", 32'(stall_count), 32'h4);
    @(negedge clk);
    wb_valid = 1'b0;
    #1;
    check("raw_release", 32'(in_ready), 32'h1);
    step();
    check("raw_valid", 32'(out_valid), 32'h1);
    check("raw_a", 32'(out_a), 32'h7777);
    check("raw_stall_hold", 32'(stall_count), 32'h4);

    // Backpressure
    @(negedge clk);
    drive(1'b1, 4'd12, 4'd3, 4'd5, 1'b0, 1'b1, 1'b1);
    step();
    check("bp_first_a", 32'(out_a), 32'h1234);
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 4'd13, 4'd5, 4'd3, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp_ready%0d", i), 32'(in_ready), 32'h0);
      step();
      check($sformatf("bp_valid%0d", i), 32'(out_valid), 32'h1);
      check($sformatf("bp_slot%0d", i), {out_a, out_b}, 32'h1234ABCD);
      check($sformatf("bp_rd%0d", i), 32'(out_rd), 32'hC);
      check($sformatf("bp_stall%0d", i), 32'(stall_count), 32'h4);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release", 32'(in_ready), 32'h1);
    step();
    check("bp_next", {out_a, out_b}, 32'hABCD1234);
    check("bp_next_rd", 32'(out_rd), 32'hD);

    // Set wins over same-cycle clear on R2
    @(negedge clk);
    drive(1'b1, 4'd2, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    step();
    @(negedge clk);
    drive(1'b1, 4'd2, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    #1;
    check("waw_ready", 32'(in_ready), 32'h0);
    drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    wb_valid = 1'b1; wb_addr = 4'd2; wb_data = 16'h2222;
    step();
    @(negedge clk);
    drive(1'b1, 4'd2, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    wb_data = 16'h2223;
    #1;
    check("sc_accept_ready", 32'(in_ready), 32'h1);
    step();
    @(negedge clk);
    wb_valid = 1'b0;
    drive(1'b0, 4'd0, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("unused_src_ready", 32'(in_ready), 32'h1);
    drive(1'b0, 4'd0, 4'd0, 4'd2, 1'b0, 1'b0, 1'b1);
    #1;
    check("sc_rt_hazard", 32'(in_ready), 32'h0);
    drive(1'b1, 4'd0, 4'd2, 4'd0, 1'b0, 1'b1, 1'b0);
    #1;
    check("sc_rs_hazard", 32'(in_ready), 32'h0);
    step();
    check("sc_stall", 32'(stall_count), 32'h5);

    // Saturation, then reset mid-stall
    repeat (65540) @(posedge clk);
    #1;
    check("sat_count", 32'(stall_count), 32'hFFFF);
    @(negedge clk);
    rst = 1'b1;
    step();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_count", 32'(stall_count), 32'h0);
    check("midrst_valid", 32'(out_valid), 32'h0);
    check("midrst_ready", 32'(in_ready), 32'h1);
    step();
    check("midrst_accept", 32'(out_valid), 32'h1);
    check("midrst_a", 32'(out_a), 32'h2223);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
